// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port, with a clear sweep.
// Optional macro RFARB_ZERO_GUARD_EN suppresses requester writes to register 0.
module regfile_wb_arbiter #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_valid,
   output logic          m0_ready,
   input  logic [AW-1:0] m0_waddr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m1_valid,
   output logic          m1_ready,
   input  logic [AW-1:0] m1_waddr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          clr_req,
   output logic          busy,
   output logic          clr_done,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata
);

   typedef enum logic {ARB, CLEAR} state_t;

   localparam logic [AW:0] CNT_END = {1'b1, {AW{1'b0}}};

   state_t        state;
   logic          last;
   logic [AW:0]   cnt;
   logic          grant0;
   logic          grant1;
   logic          arb_open;
   logic          acc;
   logic          acc_we;
   logic [AW-1:0] acc_addr;
   logic [DW-1:0] acc_data;

   always_comb begin
      grant0 = m0_valid & (~m1_valid | last);
      grant1 = m1_valid & (~m0_valid | ~last);
   end

   assign arb_open = (state == ARB) & ~clr_req;
   assign m0_ready = arb_open & grant0;
   assign m1_ready = arb_open & grant1;
   assign busy     = (state == CLEAR);

   assign acc      = m0_ready | m1_ready;
   assign acc_addr = m0_ready ? m0_waddr : m1_waddr;
   assign acc_data = m0_ready ? m0_wdata : m1_wdata;

`ifdef RFARB_ZERO_GUARD_EN
   assign acc_we = acc & (acc_addr != '0);
`else
   assign acc_we = acc;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB;
         last     <= 1'b1;
         cnt      <= '0;
         clr_done <= 1'b0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         clr_done <= 1'b0;
         unique case (state)
            ARB: begin
               if (clr_req) begin
                  // address 0 goes out on the entry edge, so the sweep
                  // occupies exactly 2**AW cycles of busy
                  state    <= CLEAR;
                  cnt      <= {{AW{1'b0}}, 1'b1};
                  rf_we    <= 1'b1;
                  rf_waddr <= '0;
                  rf_wdata <= '0;
               end else begin
                  rf_we <= acc_we;
                  if (acc) begin
                     rf_waddr <= acc_addr;
                     rf_wdata <= acc_data;
                     last     <= m1_ready;
                  end
               end
            end
            CLEAR: begin
               if (cnt == CNT_END) begin
                  state    <= ARB;
                  cnt      <= '0;
                  rf_we    <= 1'b0;
                  clr_done <= 1'b1;
               end else begin
                  rf_we    <= 1'b1;
                  rf_waddr <= cnt[AW-1:0];
                  rf_wdata <= '0;
                  cnt      <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule
